display_scan_4dig: RTL and testbench

Time-multiplexed driver for the four-digit common-anode 7-segment display. It sits directly downstream of the 1 kHz clock divider and consumes its `clk1KHz` square wave as the scan rate. It also takes the 16-bit packed BCD count from the counter core and drives one digit at a time. Between digits it inserts an all-off guard interval to suppress ghosting. Optional leading-zero blanking and decimal-point drive are included.

---
 rtl/display_scan_4dig.sv | 122 ++++++++++++
 tb/tb_display_scan_4dig.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_4dig.sv
// Four-digit multiplexed 7-segment driver with an all-off guard after each digit advance.
// Optional decimal-point path is enabled by defining DISPLAY_DP_EN.
module display_scan_4dig #(
  parameter int unsigned GUARD_CYC = 16
) (
  input  logic        clkFPGA,
  input  logic        rst_n,
  input  logic        clk1KHz,
  input  logic [15:0] bcd,
  input  logic        lz_blank,
  input  logic [3:0]  dp_in,
  output logic [3:0]  anodes,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_idx
);

  logic       s1, s2, s3;
  logic       tick;
  logic [7:0] g;
  logic       guard;
  logic [3:0] nibble;
  logic       blank;
  logic [6:0] seg_dec;

  // clk1KHz is asynchronous data here; s3 only remembers the previous synchronized level
  always_ff @(posedge clkFPGA or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk1KHz;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign tick = s2 & ~s3;

  always_ff @(posedge clkFPGA or negedge rst_n) begin
    if (!rst_n) begin
      digit_idx <= 2'd0;
      g         <= 8'd0;
    end else if (tick) begin
      digit_idx <= digit_idx + 2'd1;
      g         <= 8'(GUARD_CYC);
    end else if (g != 8'd0) begin
      g <= g - 8'd1;
    end
  end

  assign guard = (g != 8'd0);

  always_comb begin
    nibble = bcd[3:0];
    blank  = 1'b0;
    case (digit_idx)
      2'd0: nibble = bcd[3:0];
      2'd1: begin
        nibble = bcd[7:4];
        blank  = lz_blank && (bcd[15:4] == 12'd0);
      end
      2'd2: begin
        nibble = bcd[11:8];
        blank  = lz_blank && (bcd[15:8] == 8'd0);
      end
      default: begin
        nibble = bcd[15:12];
        blank  = lz_blank && (bcd[15:12] == 4'd0);
      end
    endcase
  end

  // Non-BCD nibbles light only segment g so a bad count shows as "-"
  always_comb begin
    seg_dec = 7'h3F;
    case (nibble)
      4'd0: seg_dec = 7'h40;
      4'd1: seg_dec = 7'h79;
      4'd2: seg_dec = 7'h24;
      4'd3: seg_dec = 7'h30;
      4'd4: seg_dec = 7'h19;
      4'd5: seg_dec = 7'h12;
      4'd6: seg_dec = 7'h02;
      4'd7: seg_dec = 7'h78;
      4'd8: seg_dec = 7'h00;
      4'd9: seg_dec = 7'h10;
      default: seg_dec = 7'h3F;
    endcase
  end

  always_ff @(posedge clkFPGA or negedge rst_n) begin
    if (!rst_n) begin
      anodes <= 4'b1111;
      seg    <= 7'h7F;
    end else if (guard || blank) begin
      anodes <= 4'b1111;
      seg    <= 7'h7F;
    end else begin
      anodes <= ~(4'b0001 << digit_idx);
      seg    <= seg_dec;
    end
  end

`ifdef DISPLAY_DP_EN
  always_ff @(posedge clkFPGA or negedge rst_n) begin
    if (!rst_n) begin
      dp <= 1'b1;
    end else if (guard || blank) begin
      dp <= 1'b1;
    end else begin
      dp <= ~dp_in[digit_idx];
    end
  end
`else
  logic unused_dp_in;
  assign unused_dp_in = ^dp_in;
  assign dp = 1'b1;
`endif

endmodule

// File: tb/tb_display_scan_4dig.sv
// Self-checking bench for display_scan_4dig: a time-based model of tick/guard/scan
// checked every cycle, plus directed scenarios with literal expectations.
module tb_display_scan_4dig;

  localparam int G = 4;
  localparam logic [6:0] DEC [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                      7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
  localparam logic [3:0] AN_LIT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  logic        clkFPGA = 1'b0;
  logic        rst_n = 1'b0;
  logic        clk1KHz = 1'b0;
  logic [15:0] bcd = 16'h1234;
  logic        lz_blank = 1'b0;
  logic [3:0]  dp_in = 4'b0000;
  logic [3:0]  anodes;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  digit_idx;

  int checks = 0;
  int errors = 0;

  display_scan_4dig #(.GUARD_CYC(G)) dut (
    .clkFPGA   (clkFPGA),
    .rst_n     (rst_n),
    .clk1KHz   (clk1KHz),
    .bcd       (bcd),
    .lz_blank  (lz_blank),
    .dp_in     (dp_in),
    .anodes    (anodes),
    .seg       (seg),
    .dp        (dp),
    .digit_idx (digit_idx)
  );

  always #5 clkFPGA = ~clkFPGA;

  task automatic checkOutput(input string name, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Model: a rise of clk1KHz seen at edge N advances the digit at N+2 and
  // blanks the outputs for G edges starting at N+3.
  int  t, cnt, last;
  bit  has_last, prev;
  int  pend[$];

  always @(posedge clkFPGA) begin
    int d, k, upper;
    bit off, blk;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic       e_dp;
    if (!rst_n) begin
      t = 0; cnt = 0; last = 0; has_last = 0; prev = 0;
      pend.delete();
    end else begin
      d = cnt % 4;
      upper = int'(bcd >> (4 * d));
      blk = lz_blank && (d > 0) && (upper == 0);
      k = t - 1 - (last + 2);
      off = blk || (has_last && (G - k > 0));
      e_an  = off ? 4'b1111 : 4'(~(32'd1 << d));
      e_seg = off ? 7'h7F : DEC[upper % 16];
`ifdef DISPLAY_DP_EN
      e_dp  = off ? 1'b1 : ~dp_in[d];
`else
      e_dp  = 1'b1;
`endif
      if (clk1KHz && !prev) pend.push_back(t);
      prev = clk1KHz;
      while (pend.size() > 0 && pend[0] + 2 <= t) begin
        last = pend.pop_front();
        cnt++;
        has_last = 1;
      end
      t++;
      #1;
      checkOutput("model_anodes", 16'(anodes), 16'(e_an));
      checkOutput("model_seg", 16'(seg), 16'(e_seg));
      checkOutput("model_dp", 16'(dp), 16'(e_dp));
      checkOutput("model_digit_idx", 16'(digit_idx), 16'(cnt % 4));
    end
  end

  task automatic applyStimulus(input logic [15:0] b, input logic lz, input logic [3:0] dpi);
    @(negedge clkFPGA);
    bcd = b;
    lz_blank = lz;
    dp_in = dpi;
  endtask

  // One-clock clk1KHz pulse; returns sampled #1 after edge N+7, where the new digit is lit
  task automatic doTick();
    @(negedge clkFPGA);
    clk1KHz = 1'b1;
    @(posedge clkFPGA);
    @(negedge clkFPGA);
    clk1KHz = 1'b0;
    repeat (7) @(posedge clkFPGA);
    #1;
  endtask

  task automatic tickUntil(input logic [1:0] target);
    for (int i = 0; i < 4 && digit_idx != target; i++) doTick();
    checkOutput("reach_digit", 16'(digit_idx), 16'(target));
  endtask

  initial begin
    int off_cnt;
    logic [1:0] idx0;
    logic       dp_exp;

    repeat (3) @(negedge clkFPGA);
    #1;
    checkOutput("reset_anodes", 16'(anodes), 16'h000F);
    checkOutput("reset_seg", 16'(seg), 16'h007F);
    checkOutput("reset_dp", 16'(dp), 16'h0001);
    checkOutput("reset_idx", 16'(digit_idx), 16'h0000);
    @(negedge clkFPGA);
    rst_n = 1'b1;

    // Scan and latency with bcd=1234
    applyStimulus(16'h1234, 1'b0, 4'b0000);
    repeat (2) @(posedge clkFPGA);
    #1;
    checkOutput("digit0_anodes", 16'(anodes), 16'h000E);
    checkOutput("digit0_seg", 16'(seg), 16'h0019);
    @(negedge clkFPGA);
    clk1KHz = 1'b1;
    @(posedge clkFPGA);
    @(negedge clkFPGA);
    clk1KHz = 1'b0;
    @(posedge clkFPGA);
    #1;
    checkOutput("lat_idx_n1", 16'(digit_idx), 16'h0000);
    @(posedge clkFPGA);
    #1;
    checkOutput("lat_idx_n2", 16'(digit_idx), 16'h0001);
    off_cnt = 0;
    repeat (4) begin
      @(posedge clkFPGA);
      #1;
      if (anodes == 4'b1111 && seg == 7'h7F) off_cnt++;
    end
    checkOutput("guard_off_cycles", 16'(off_cnt), 16'd4);
    @(posedge clkFPGA);
    #1;
    checkOutput("lat_n7_anodes", 16'(anodes), 16'h000D);
    checkOutput("lat_n7_seg", 16'(seg), 16'h0030);
    doTick();
    checkOutput("scan2_anodes", 16'(anodes), 16'h000B);
    checkOutput("scan2_seg", 16'(seg), 16'h0024);
    doTick();
    checkOutput("scan3_anodes", 16'(anodes), 16'h0007);
    checkOutput("scan3_seg", 16'(seg), 16'h0079);
    doTick();
    checkOutput("wrap_idx", 16'(digit_idx), 16'h0000);
    checkOutput("wrap_seg", 16'(seg), 16'h0019);

    // Leading-zero blanking
    applyStimulus(16'h0050, 1'b1, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      doTick();
      case (digit_idx)
        2'd0: checkOutput("lz_d0_seg", 16'(seg), 16'h0040);
        2'd1: checkOutput("lz_d1_seg", 16'(seg), 16'h0012);
        default: checkOutput("lz_hi_blank", 16'(anodes), 16'h000F);
      endcase
    end
    applyStimulus(16'h0050, 1'b0, 4'b0000);
    for (int i = 0; i < 4; i++) begin
      doTick();
      checkOutput("nolz_lit", 16'(anodes), 16'(AN_LIT[digit_idx]));
    end

    // Illegal nibble
    applyStimulus(16'h00A0, 1'b0, 4'b0000);
    tickUntil(2'd1);
    checkOutput("illegal_seg", 16'(seg), 16'h003F);

    // Decimal point on digit 2
    applyStimulus(16'h1234, 1'b0, 4'b0100);
`ifdef DISPLAY_DP_EN
    dp_exp = 1'b0;
`else
    dp_exp = 1'b1;
`endif
    tickUntil(2'd2);
    checkOutput("dp_digit2", 16'(dp), 16'(dp_exp));
    doTick();
    checkOutput("dp_digit3", 16'(dp), 16'h0001);

    // Tick density: short pulse, then a long high level
    idx0 = digit_idx;
    @(negedge clkFPGA);
    clk1KHz = 1'b1;
    @(negedge clkFPGA);
    clk1KHz = 1'b0;
    repeat (5) @(negedge clkFPGA);
    clk1KHz = 1'b1;
    repeat (100) @(negedge clkFPGA);
    clk1KHz = 1'b0;
    repeat (10) @(negedge clkFPGA);
    checkOutput("density_adv", 16'(digit_idx), 16'(2'(idx0 + 2'd2)));

    // Back-to-back ticks two cycles apart restart the guard
    idx0 = digit_idx;
    @(negedge clkFPGA); clk1KHz = 1'b1;
    @(posedge clkFPGA);
    @(negedge clkFPGA); clk1KHz = 1'b0;
    @(posedge clkFPGA);
    @(negedge clkFPGA); clk1KHz = 1'b1;
    @(posedge clkFPGA);
    @(negedge clkFPGA); clk1KHz = 1'b0;
    off_cnt = 0;
    repeat (6) begin
      @(posedge clkFPGA);
      #1;
      if (anodes == 4'b1111) off_cnt++;
    end
    checkOutput("b2b_off_cycles", 16'(off_cnt), 16'd6);
    @(posedge clkFPGA);
    #1;
    checkOutput("b2b_lit", 16'(anodes), 16'(AN_LIT[2'(idx0 + 2'd2)]));

    // Asynchronous reset mid-scan with digit 2 lit
    applyStimulus(16'h1234, 1'b0, 4'b0000);
    tickUntil(2'd2);
    @(negedge clkFPGA);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_anodes", 16'(anodes), 16'h000F);
    checkOutput("async_rst_seg", 16'(seg), 16'h007F);
    checkOutput("async_rst_dp", 16'(dp), 16'h0001);
    @(negedge clkFPGA);
    rst_n = 1'b1;
    doTick();
    checkOutput("post_rst_idx", 16'(digit_idx), 16'h0001);
    checkOutput("post_rst_anodes", 16'(anodes), 16'h000D);

    repeat (3) @(negedge clkFPGA);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
